// File: rtl/sha3_byte_packer_if.sv
// Byte-stream and padder word-port bundle for sha3_byte_packer.
// msg_bytes exists only when SHA3_PACKER_LEN_COUNT_EN is defined.
interface sha3_byte_packer_if #(
    parameter int LEN_W = 16
) ();
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic        msg_end;
    logic        byte_ack;
    logic [31:0] out;
    logic        out_ready;
    logic        out_last;
    logic [1:0]  out_byte_num;
    logic        buffer_full;
    logic        done;
`ifdef SHA3_PACKER_LEN_COUNT_EN
    logic [LEN_W-1:0] msg_bytes;
`endif

    modport master (
        output byte_in, byte_valid, byte_last, msg_end, buffer_full,
        input  byte_ack, out, out_ready, out_last, out_byte_num, done
`ifdef SHA3_PACKER_LEN_COUNT_EN
        , input msg_bytes
`endif
    );

    modport slave (
        input  byte_in, byte_valid, byte_last, msg_end, buffer_full,
        output byte_ack, out, out_ready, out_last, out_byte_num, done
`ifdef SHA3_PACKER_LEN_COUNT_EN
        , output msg_bytes
`endif
    );
endinterface

// File: rtl/sha3_byte_packer.sv
// Packs a byte stream big-endian into 32-bit words for the SHA3-256 padder.
// Define SHA3_PACKER_LEN_COUNT_EN to add the saturating msg_bytes counter.
module sha3_byte_packer #(
    parameter int LEN_W = 16
) (
    input logic              clk,
    input logic              reset,
    sha3_byte_packer_if.slave bus
);
    typedef enum logic [1:0] {
        ACCEPT,
        FLUSH,
        LAST_WAIT,
        DONE
    } state_t;

    state_t      state, state_n;
    logic [31:0] acc, acc_n;
    logic [1:0]  cnt, cnt_n;
    logic [31:0] out_q, out_n;
    logic        rdy_q, rdy_n;
    logic        last_q, last_n;
    logic [1:0]  bn_q, bn_n;

    logic        slot_free;
    logic        consumed;
    logic        ack;
    logic        take_byte;
    logic        take_end;
    logic [31:0] merged;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ACCEPT;
            acc    <= '0;
            cnt    <= '0;
            out_q  <= '0;
            rdy_q  <= 1'b0;
            last_q <= 1'b0;
            bn_q   <= '0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            out_q  <= out_n;
            rdy_q  <= rdy_n;
            last_q <= last_n;
            bn_q   <= bn_n;
        end
    end

    always_comb begin
        slot_free = !rdy_q || !bus.buffer_full;
        consumed  = rdy_q && !bus.buffer_full;
        // Mid-word bytes can be taken even while the slot is blocked.
        ack = (state == ACCEPT) &&
              (slot_free ||
               (!bus.byte_last && !bus.msg_end && cnt != 2'd3));
        take_byte = ack && bus.byte_valid;
        take_end  = ack && bus.msg_end && !bus.byte_valid;

        merged = acc;
        unique case (cnt)
            2'd0: merged[31:24] = bus.byte_in;
            2'd1: merged[23:16] = bus.byte_in;
            2'd2: merged[15:8]  = bus.byte_in;
            2'd3: merged[7:0]   = bus.byte_in;
        endcase

        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        out_n   = out_q;
        rdy_n   = rdy_q && !consumed;
        last_n  = last_q;
        bn_n    = bn_q;

        unique case (state)
            ACCEPT: begin
                if (take_byte) begin
                    if (bus.byte_last || cnt == 2'd3) begin
                        out_n = merged;
                        rdy_n = 1'b1;
                        acc_n = '0;
                        cnt_n = '0;
                        if (!bus.byte_last) begin
                            last_n = 1'b0;
                            bn_n   = 2'd0;
                        end else if (cnt == 2'd3) begin
                            last_n  = 1'b0;
                            bn_n    = 2'd0;
                            state_n = FLUSH;
                        end else begin
                            last_n  = 1'b1;
                            bn_n    = cnt + 2'd1;
                            state_n = LAST_WAIT;
                        end
                    end else begin
                        acc_n = merged;
                        cnt_n = cnt + 2'd1;
                    end
                end else if (take_end) begin
                    out_n   = acc;
                    rdy_n   = 1'b1;
                    last_n  = 1'b1;
                    bn_n    = cnt;
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = LAST_WAIT;
                end
            end
            FLUSH: begin
                // Empty terminating word owed after a full final word.
                if (slot_free) begin
                    out_n   = '0;
                    rdy_n   = 1'b1;
                    last_n  = 1'b1;
                    bn_n    = 2'd0;
                    state_n = LAST_WAIT;
                end
            end
            LAST_WAIT: begin
                if (consumed) state_n = DONE;
            end
            DONE: begin
            end
        endcase
    end

    assign bus.byte_ack     = ack;
    assign bus.out          = out_q;
    assign bus.out_ready    = rdy_q;
    assign bus.out_last     = last_q;
    assign bus.out_byte_num = bn_q;
    assign bus.done         = (state == DONE);

`ifdef SHA3_PACKER_LEN_COUNT_EN
    logic [LEN_W-1:0] len_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q <= '0;
        end else if (take_byte && len_q != {LEN_W{1'b1}}) begin
            len_q <= len_q + 1'b1;
        end
    end

    assign bus.msg_bytes = len_q;
`endif
endmodule

// File: tb/tb_sha3_byte_packer.sv
// Self-checking bench for sha3_byte_packer: vector table plus
// hand-written back-pressure, lockout and reset sequences.
module tb_sha3_byte_packer;
    logic clk;
    logic reset;

    sha3_byte_packer_if #(.LEN_W(16)) bus ();

    sha3_byte_packer #(.LEN_W(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic        l;
        logic [1:0]  bn;
    } exp_t;

    typedef struct {
        int          n;
        logic [63:0] d;
        bit          via_end;
        bit          bp;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    bit   bp_rand = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Consumption edge follows a negedge with out_ready=1 and buffer_full=0.
    always @(negedge clk) begin
        if (!reset && bus.out_ready && !bus.buffer_full) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_word: got %h want none", bus.out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("word", bus.out, e.w);
                chk("word_last", {31'd0, bus.out_last}, {31'd0, e.l});
                chk("word_bn", {30'd0, bus.out_byte_num}, {30'd0, e.bn});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_rand) bus.buffer_full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_last = 1'b0;
        bus.msg_end = 1'b0;
        bus.byte_in = 8'h00;
        bus.buffer_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Full words are not last; the final word holds n%4 bytes, marked last.
    task automatic push_msg(int n, logic [63:0] d);
        exp_t e;
        int i;
        i = 0;
        while (n - i >= 4) begin
            e.w = d[63-8*i -: 32];
            e.l = 1'b0;
            e.bn = 2'd0;
            q.push_back(e);
            i += 4;
        end
        e.w = 32'h0;
        for (int k = 0; k < n - i; k++) e.w[31-8*k -: 8] = d[63-8*(i+k) -: 8];
        e.l = 1'b1;
        e.bn = 2'(n - i);
        q.push_back(e);
    endtask

    task automatic handshake(string name);
        bit got;
        got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (bus.byte_ack) got = 1;
            tick();
        end
        bus.byte_valid = 1'b0;
        bus.byte_last = 1'b0;
        bus.msg_end = 1'b0;
        if (!got) begin
            checks++;
            $display("FAIL %s_timeout: got no ack want ack", name);
        end
    endtask

    task automatic send_byte(logic [7:0] b, bit last);
        bus.byte_in = b;
        bus.byte_valid = 1'b1;
        bus.byte_last = last;
        handshake("send_byte");
    endtask

    task automatic send_end();
        bus.msg_end = 1'b1;
        handshake("msg_end");
    endtask

    task automatic wait_done(string name);
        bit got;
        got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (bus.done) got = 1;
            else tick();
        end
        chk($sformatf("%s_done", name), {31'd0, got}, 32'd1);
        chk($sformatf("%s_queue_empty", name), q.size(), 0);
        bp_rand = 0;
        bus.buffer_full = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1, 64'h9000000000000000, 1'b0, 1'b0};
        vecs[1] = '{4, 64'h90ABCDEF00000000, 1'b0, 1'b0};
        vecs[2] = '{0, 64'h0, 1'b1, 1'b0};
        vecs[3] = '{3, 64'h1122330000000000, 1'b0, 1'b1};
        vecs[4] = '{5, 64'hA1A2A3A4A5000000, 1'b1, 1'b1};
        vecs[5] = '{8, 64'h0102030405060708, 1'b0, 1'b1};
        vecs[6] = '{2, 64'hFE01000000000000, 1'b1, 1'b0};
        vecs[7] = '{4, 64'hDEADBEEF00000000, 1'b1, 1'b1};
        vecs[8] = '{6, 64'h3C3D3E3F40410000, 1'b0, 1'b1};

        reset = 1'b1;
        do_reset();
        @(negedge clk);
        chk("rst_out", bus.out, 32'h0);
        chk("rst_ready", {31'd0, bus.out_ready}, 32'd0);
        chk("rst_last", {31'd0, bus.out_last}, 32'd0);
        chk("rst_bn", {30'd0, bus.out_byte_num}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);

        for (int v = 0; v < 9; v++) begin
            do_reset();
            push_msg(vecs[v].n, vecs[v].d);
            bp_rand = vecs[v].bp;
            for (int i = 0; i < vecs[v].n; i++)
                send_byte(vecs[v].d[63-8*i -: 8],
                          !vecs[v].via_end && i == vecs[v].n - 1);
            if (vecs[v].via_end) send_end();
            wait_done($sformatf("vec%0d", v));
        end

        // Back-pressure on the first word of a 7-byte message.
        do_reset();
        push_msg(7, 64'h0102030405060700);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        bus.buffer_full = 1'b1;
        for (int i = 5; i <= 6; i++) begin
            bus.byte_in = 8'(i);
            bus.byte_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_ack%0d", i), {31'd0, bus.byte_ack}, 32'd1);
            chk("bp_stable", bus.out, 32'h01020304);
            @(posedge clk);
            #1;
        end
        bus.byte_in = 8'h07;
        bus.byte_last = 1'b1;
        @(negedge clk);
        chk("bp_ack7_low", {31'd0, bus.byte_ack}, 32'd0);
        chk("bp_stable7", bus.out, 32'h01020304);
        chk("bp_ready", {31'd0, bus.out_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.buffer_full = 1'b0;
        @(negedge clk);
        chk("bp_ack7_release", {31'd0, bus.byte_ack}, 32'd1);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        bus.byte_last = 1'b0;
        wait_done("bp");
`ifdef SHA3_PACKER_LEN_COUNT_EN
        chk("msg_bytes", 32'(bus.msg_bytes), 32'd7);
`endif

        // Lockout after done.
        bus.byte_in = 8'h55;
        bus.byte_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("lock_ack", {31'd0, bus.byte_ack}, 32'd0);
            chk("lock_ready", {31'd0, bus.out_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b0;

        // Reset mid-message discards the partial word.
        do_reset();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        do_reset();
        @(negedge clk);
        chk("midrst_ready", {31'd0, bus.out_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        push_msg(1, 64'h9000000000000000);
        send_byte(8'h90, 1'b1);
        wait_done("after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
